// File: rtl/eth_header_parser.sv
// Ethernet header field extractor: samples an 18-byte header and presents decoded fields one cycle later.
// Define ETH_PARSER_VLAN_EN to decode a single 802.1Q tag (bytes 14-17); otherwise those bytes are ignored.
module eth_header_parser #(
    parameter int HDR_BYTES = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*HDR_BYTES-1:0] header_bytes,
    input  logic                   header_valid,
    output logic [47:0]            dest_mac,
    output logic [47:0]            src_mac,
    output logic [15:0]            ethertype_raw,
    output logic [15:0]            ethertype,
    output logic                   vlan_present,
    output logic [15:0]            vlan_tci,
    output logic [4:0]             hdr_len,
    output logic                   is_broadcast,
    output logic                   is_multicast,
    output logic                   is_length,
    output logic                   fields_valid
);

    localparam logic [15:0] TPID_8021Q = 16'h8100;
    localparam logic [15:0] MIN_TYPE   = 16'h0600;

    logic [111:0] base_q;
    logic         loaded_q;
    logic         pulse_q;

    // The whole header is captured on one edge, so every derived field comes from the same sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            loaded_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= header_valid;
            if (header_valid) begin
                base_q   <= header_bytes[143:32];
                loaded_q <= 1'b1;
            end
        end
    end

    assign dest_mac      = base_q[111:64];
    assign src_mac       = base_q[63:16];
    assign ethertype_raw = base_q[15:0];
    assign fields_valid  = pulse_q;
    assign is_broadcast  = &dest_mac;
    assign is_multicast  = dest_mac[40];

`ifdef ETH_PARSER_VLAN_EN
    logic [31:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else if (header_valid) begin
            tag_q <= header_bytes[31:0];
        end
    end

    // Only a plain 802.1Q TPID counts as tagged; 88A8 and anything else fall through as untagged.
    assign vlan_present = (ethertype_raw == TPID_8021Q);
    assign vlan_tci     = vlan_present ? tag_q[31:16] : 16'h0000;
    assign ethertype    = vlan_present ? tag_q[15:0] : ethertype_raw;
    assign hdr_len      = !loaded_q ? 5'd0 : (vlan_present ? 5'd18 : 5'd14);
`else
    logic unused_tag;
    logic unused_tpid;

    assign unused_tag   = ^header_bytes[31:0];
    assign unused_tpid  = ^TPID_8021Q;
    assign vlan_present = 1'b0;
    assign vlan_tci     = 16'h0000;
    assign ethertype    = ethertype_raw;
    assign hdr_len      = loaded_q ? 5'd14 : 5'd0;
`endif

    // Gated by loaded_q so the cleared register does not read as a zero-length 802.3 frame.
    assign is_length = loaded_q && (ethertype < MIN_TYPE);

endmodule

// File: tb/tb_eth_header_parser.sv
// Self-checking bench for eth_header_parser: directed literal cases plus randomized headers
// checked every cycle against a byte-level model of the header rules.
module tb_eth_header_parser;

`ifdef ETH_PARSER_VLAN_EN
    localparam bit VLAN_EN = 1'b1;
`else
    localparam bit VLAN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [143:0] header_bytes = '0;
    logic         header_valid = 1'b0;
    logic [47:0]  dest_mac, src_mac;
    logic [15:0]  ethertype_raw, ethertype, vlan_tci;
    logic         vlan_present, is_broadcast, is_multicast, is_length, fields_valid;
    logic [4:0]   hdr_len;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    eth_header_parser #(.HDR_BYTES(18)) dut (
        .clk           (clk),
        .rst           (rst),
        .header_bytes  (header_bytes),
        .header_valid  (header_valid),
        .dest_mac      (dest_mac),
        .src_mac       (src_mac),
        .ethertype_raw (ethertype_raw),
        .ethertype     (ethertype),
        .vlan_present  (vlan_present),
        .vlan_tci      (vlan_tci),
        .hdr_len       (hdr_len),
        .is_broadcast  (is_broadcast),
        .is_multicast  (is_multicast),
        .is_length     (is_length),
        .fields_valid  (fields_valid)
    );

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] raw;
        logic [15:0] etype;
        logic [15:0] tci;
        logic        vlan;
        logic [4:0]  len;
        logic        bc;
        logic        mc;
        logic        islen;
        logic        fv;
    } fields_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] hbyte(input logic [143:0] h, input int n);
        return h[143-8*n -: 8];
    endfunction

    function automatic logic [143:0] mk(input logic [47:0] d, input logic [47:0] s,
                                        input logic [15:0] t, input logic [15:0] tci,
                                        input logic [15:0] inner);
        return {d, s, t, tci, inner};
    endfunction

    // Reference: what the outputs must be given the last accepted header, from byte-level rules.
    function automatic fields_t expectFields(input logic [143:0] h, input bit loaded, input bit pulse);
        fields_t f;
        f = '0;
        if (!loaded) return f;
        for (int i = 0; i < 6; i++) f.dest = (f.dest << 8) | 48'(hbyte(h, i));
        for (int i = 6; i < 12; i++) f.src = (f.src << 8) | 48'(hbyte(h, i));
        f.raw   = {hbyte(h, 12), hbyte(h, 13)};
        f.vlan  = VLAN_EN && (f.raw == 16'h8100);
        f.etype = f.vlan ? {hbyte(h, 16), hbyte(h, 17)} : f.raw;
        f.tci   = f.vlan ? {hbyte(h, 14), hbyte(h, 15)} : 16'h0;
        f.len   = f.vlan ? 5'd18 : 5'd14;
        f.bc    = (f.dest == {48{1'b1}});
        f.mc    = hbyte(h, 0) & 8'h01;
        f.islen = (f.etype < 16'h0600);
        f.fv    = pulse;
        return f;
    endfunction

    logic [143:0] mHdr = '0;
    bit           mLoaded = 1'b0;
    bit           mPulse = 1'b0;

    // Track which header the DUT should be presenting and whether a pulse is due.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mLoaded = 1'b0;
            mPulse  = 1'b0;
        end else if (header_valid) begin
            mHdr    = header_bytes;
            mLoaded = 1'b1;
            mPulse  = 1'b1;
        end else begin
            mPulse = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        fields_t e;
        e = rst ? '0 : expectFields(mHdr, mLoaded, mPulse);
        checkOutput("dest_mac", 64'(dest_mac), 64'(e.dest));
        checkOutput("src_mac", 64'(src_mac), 64'(e.src));
        checkOutput("ethertype_raw", 64'(ethertype_raw), 64'(e.raw));
        checkOutput("ethertype", 64'(ethertype), 64'(e.etype));
        checkOutput("vlan_present", 64'(vlan_present), 64'(e.vlan));
        checkOutput("vlan_tci", 64'(vlan_tci), 64'(e.tci));
        checkOutput("hdr_len", 64'(hdr_len), 64'(e.len));
        checkOutput("is_broadcast", 64'(is_broadcast), 64'(e.bc));
        checkOutput("is_multicast", 64'(is_multicast), 64'(e.mc));
        checkOutput("is_length", 64'(is_length), 64'(e.islen));
        checkOutput("fields_valid", 64'(fields_valid), 64'(e.fv));
    end

    task automatic applyStimulus(input logic [143:0] h, input logic v);
        @(posedge clk);
        #1;
        header_bytes = h;
        header_valid = v;
    endtask

    function automatic logic [143:0] randomHeader();
        logic [63:0]  r;
        logic [47:0]  d;
        logic [15:0]  t;
        logic [15:0]  types [8];
        types = '{16'h0800, 16'h86DD, 16'h8100, 16'h88A8, 16'h05DC, 16'h0600, 16'h05FF, 16'h0000};
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       d = {48{1'b1}};
            1:       d = {8'h01, r[39:0]};
            2:       d = r[47:0] & ~48'h0100_0000_0000;
            default: d = r[47:0];
        endcase
        t = types[$urandom_range(0, 7)];
        if (t == 16'h0000) t = 16'($urandom);
        if (t == 16'h8100 && VLAN_EN) begin
            r = {$urandom, $urandom};
            return mk(d, 48'({$urandom, $urandom}), t, r[15:0], types[$urandom_range(0, 1)]);
        end
        r = {$urandom, $urandom};
        return mk(d, 48'({$urandom, $urandom}), t, r[15:0], r[31:16]);
    endfunction

    logic [143:0] hA, hB, hC;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset fields_valid", 64'(fields_valid), 64'd0);
        checkOutput("reset hdr_len", 64'(hdr_len), 64'd0);
        checkOutput("reset is_length", 64'(is_length), 64'd0);
        #2 rst = 1'b0;

        // IPv4 broadcast
        applyStimulus(mk(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 16'h0, 16'h0), 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("ipv4 fields_valid", 64'(fields_valid), 64'd1);
        checkOutput("ipv4 dest_mac", 64'(dest_mac), 64'hFFFF_FFFF_FFFF);
        checkOutput("ipv4 src_mac", 64'(src_mac), 64'h0011_2233_4455);
        checkOutput("ipv4 ethertype_raw", 64'(ethertype_raw), 64'h0800);
        checkOutput("ipv4 is_broadcast", 64'(is_broadcast), 64'd1);
        checkOutput("ipv4 is_multicast", 64'(is_multicast), 64'd1);
        checkOutput("ipv4 hdr_len", 64'(hdr_len), 64'd14);

        // 802.1Q tagged IPv6
        applyStimulus(mk(48'h02AA_BBCC_DDEE, 48'h0011_2233_4455, 16'h8100, 16'h6064, 16'h86DD), 1'b1);
        applyStimulus('0, 1'b0);
`ifdef ETH_PARSER_VLAN_EN
        checkOutput("vlan vlan_present", 64'(vlan_present), 64'd1);
        checkOutput("vlan vlan_tci", 64'(vlan_tci), 64'h6064);
        checkOutput("vlan ethertype", 64'(ethertype), 64'h86DD);
        checkOutput("vlan hdr_len", 64'(hdr_len), 64'd18);
`else
        checkOutput("vlan vlan_present", 64'(vlan_present), 64'd0);
        checkOutput("vlan vlan_tci", 64'(vlan_tci), 64'h0);
        checkOutput("vlan ethertype", 64'(ethertype), 64'h8100);
        checkOutput("vlan hdr_len", 64'(hdr_len), 64'd14);
`endif

        // 802.3 length frame to a multicast group
        applyStimulus(mk(48'h0100_5E00_0001, 48'h0011_2233_4455, 16'h05DC, 16'hAAAA, 16'h0300), 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("8023 is_length", 64'(is_length), 64'd1);
        checkOutput("8023 is_multicast", 64'(is_multicast), 64'd1);
        checkOutput("8023 is_broadcast", 64'(is_broadcast), 64'd0);

        // Back-to-back A then B
        hA = mk(48'h0A0B_0C0D_0E0F, 48'h1111_1111_1111, 16'h0800, 16'h0, 16'h0);
        hB = mk(48'h2030_4050_6070, 48'h2222_2222_2222, 16'h88A8, 16'h1234, 16'h0800);
        applyStimulus(hA, 1'b1);
        applyStimulus(hB, 1'b1);
        checkOutput("b2b A fields_valid", 64'(fields_valid), 64'd1);
        checkOutput("b2b A dest_mac", 64'(dest_mac), 64'h0A0B_0C0D_0E0F);
        applyStimulus('0, 1'b0);
        checkOutput("b2b B fields_valid", 64'(fields_valid), 64'd1);
        checkOutput("b2b B dest_mac", 64'(dest_mac), 64'h2030_4050_6070);
        checkOutput("b2b B vlan_present", 64'(vlan_present), 64'd0);
        checkOutput("b2b B ethertype", 64'(ethertype), 64'h88A8);
        applyStimulus('0, 1'b0);
        checkOutput("b2b idle fields_valid", 64'(fields_valid), 64'd0);
        checkOutput("b2b held src_mac", 64'(src_mac), 64'h2222_2222_2222);

        // Reset while a header is offered, then resume on the next edge
        hC = mk(48'h0000_0000_00C0, 48'h3333_3333_3333, 16'h0806, 16'h0, 16'h0);
        applyStimulus(hC, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst dest_mac", 64'(dest_mac), 64'd0);
        checkOutput("rst ethertype", 64'(ethertype), 64'd0);
        checkOutput("rst hdr_len", 64'(hdr_len), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rst no pulse", 64'(fields_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        header_valid = 1'b0;
        checkOutput("resume fields_valid", 64'(fields_valid), 64'd1);
        checkOutput("resume src_mac", 64'(src_mac), 64'h3333_3333_3333);
        checkOutput("resume ethertype", 64'(ethertype), 64'h0806);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randomHeader(), 1'($urandom_range(0, 9) < 6));
            rst = ($urandom_range(0, 39) == 0);
        end
        applyStimulus('0, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
